// File: rtl/uart_tx_seq.sv
// Frame sequencer: holds one request on the converter and sends its non-zero bytes (slot 4..1) as 8N1, 10*BAUD_DIV+1 cycles per byte.
// Each empty slot costs 1 cycle; req_ready is high only in IDLE, and requests that arrive while busy are dropped, not queued.
module uart_tx_seq #(
  parameter int BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_all,
  input  logic        req_type_tx,
  input  logic        req_data_mode,
  output logic [3:0]  cnt,
  output logic [31:0] all,
  output logic        type_tx,
  output logic        data_mode,
  input  logic [7:0]  dout,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, SEL, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [3:0]    cnt_nxt;
  logic          txd_nxt;
  logic          done_nxt;
  logic          baud_end;
  logic          accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign baud_end  = (baud_cnt == BAUD_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;
    baud_nxt  = baud_end ? '0 : baud_cnt + 1'b1;

    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (accept) begin
          state_nxt = SEL;
          cnt_nxt   = 4'd4;
        end
      end
      SEL: begin
        baud_nxt = '0;
        bit_nxt  = 3'd0;
        if (dout != 8'h00) begin
          shreg_nxt = dout;
          state_nxt = START;
        end else if (cnt == 4'd1) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      START: begin
        if (baud_end) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (cnt == 4'd1) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SEL;
            cnt_nxt   = cnt - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    // txd is registered, so it follows the state the line will be in next cycle
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shreg_nxt[bit_nxt];
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      cnt       <= 4'd0;
      all       <= 32'h0;
      type_tx   <= 1'b0;
      data_mode <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      txd      <= txd_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      if (accept) begin
        all       <= req_all;
        type_tx   <= req_type_tx;
        data_mode <= req_data_mode;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_seq.sv
// Directed bench for uart_tx_seq with BAUD_DIV=4 and a stub hex-to-character converter.
module tb_uart_tx_seq;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_all = 32'h0;
  logic        req_type_tx = 1'b0;
  logic        req_data_mode = 1'b0;
  logic        req_ready;
  logic [3:0]  cnt_o;
  logic [31:0] all_o;
  logic        type_tx_o, data_mode_o;
  logic [7:0]  dout;
  logic        txd, busy, done;

  int n_chk = 0;
  int n_err = 0;

  logic       exp_txd[$];
  logic [3:0] exp_cnt[$];
  int         done_off;

  always #5 clk = ~clk;

  uart_tx_seq #(.BAUD_DIV(D)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_all(req_all), .req_type_tx(req_type_tx), .req_data_mode(req_data_mode),
    .cnt(cnt_o), .all(all_o), .type_tx(type_tx_o), .data_mode(data_mode_o),
    .dout(dout), .txd(txd), .busy(busy), .done(done)
  );

  // Stub converter: only the encodings this bench uses
  function automatic logic [31:0] conv_mid(input logic [31:0] w, input logic t, input logic d);
    case ({t, d})
      2'b01:   conv_mid = 32'h00000D0A;
      2'b11:   conv_mid = (w == 32'h0100003A) ? 32'h49003341 : w;
      default: conv_mid = w;
    endcase
  endfunction

  function automatic logic [7:0] slot_byte(input logic [31:0] mid, input logic [3:0] s);
    logic [31:0] sh;
    sh = 32'h0;
    if (s >= 4'd1 && s <= 4'd4) sh = mid >> (8 * (int'(s) - 1));
    slot_byte = sh[7:0];
  endfunction

  assign dout = slot_byte(conv_mid(all_o, type_tx_o, data_mode_o), cnt_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line/cnt per cycle offset from acceptance; index 0 is the accept cycle
  function automatic void build_exp(input logic [31:0] mid);
    logic [7:0]  b;
    logic [31:0] sh;
    logic        lvl;
    exp_txd.delete();
    exp_cnt.delete();
    exp_txd.push_back(1'b1);
    exp_cnt.push_back(4'd0);
    for (int s = 4; s >= 1; s--) begin
      sh = mid >> (8 * (s - 1));
      b  = sh[7:0];
      exp_txd.push_back(1'b1);
      exp_cnt.push_back(4'(s));
      if (b != 8'h00) begin
        for (int j = 0; j < 10; j++) begin
          lvl = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
          for (int r = 0; r < D; r++) begin
            exp_txd.push_back(lvl);
            exp_cnt.push_back(4'(s));
          end
        end
      end
    end
    done_off = exp_txd.size();
  endfunction

  task automatic request(input logic [31:0] w, input logic t, input logic d);
    @(negedge clk);
    chk("done_clear", {31'h0, done}, 32'h0);
    req_all = w;
    req_type_tx = t;
    req_data_mode = d;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    chk("accept_ready", {31'h0, req_ready}, 32'h1);
  endtask

  // Starts in the accept cycle and ends in the done cycle (or at abort_at)
  task automatic run_frame(input string name, input logic [31:0] mid, input logic [31:0] exp_all,
                           input logic hold, input logic [31:0] nw, input logic nt, input logic nd,
                           input int abort_at);
    build_exp(mid);
    for (int k = 1; k <= done_off; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          req_all = nw;
          req_type_tx = nt;
          req_data_mode = nd;
        end else begin
          req_valid = 1'b0;
        end
      end
      if (k < done_off) begin
        chk($sformatf("%s k%0d txd", name, k), {31'h0, txd}, {31'h0, exp_txd[k]});
        chk($sformatf("%s k%0d cnt", name, k), {28'h0, cnt_o}, {28'h0, exp_cnt[k]});
        chk($sformatf("%s k%0d busy", name, k), {31'h0, busy}, 32'h1);
        chk($sformatf("%s k%0d done", name, k), {31'h0, done}, 32'h0);
        chk($sformatf("%s k%0d ready", name, k), {31'h0, req_ready}, 32'h0);
        chk($sformatf("%s k%0d all", name, k), all_o, exp_all);
      end else begin
        chk($sformatf("%s end txd", name), {31'h0, txd}, 32'h1);
        chk($sformatf("%s end cnt", name), {28'h0, cnt_o}, 32'h0);
        chk($sformatf("%s end busy", name), {31'h0, busy}, 32'h0);
        chk($sformatf("%s end done", name), {31'h0, done}, 32'h1);
        chk($sformatf("%s end ready", name), {31'h0, req_ready}, 32'h1);
      end
      if (k == abort_at) return;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst txd", {31'h0, txd}, 32'h1);
    chk("rst ready", {31'h0, req_ready}, 32'h1);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst cnt", {28'h0, cnt_o}, 32'h0);
    chk("rst all", all_o, 32'h0);
    chk("rst modes", {30'h0, type_tx_o, data_mode_o}, 32'h0);
    rstn = 1'b1;

    // Newline: slots 4,3 skipped, CR then LF, done at T+85
    request(32'h000000FF, 1'b0, 1'b1);
    run_frame("nl", 32'h00000D0A, 32'h000000FF, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    chk("nl done_off", done_off, 85);

    // Coded: 0x49, skip, 0x33, 0x41
    request(32'h0100003A, 1'b1, 1'b1);
    run_frame("coded", 32'h49003341, 32'h0100003A, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    chk("coded modes", {30'h0, type_tx_o, data_mode_o}, 32'h3);

    // Empty frame: done at T+5, line idle throughout
    request(32'h00000000, 1'b1, 1'b0);
    run_frame("empty", 32'h00000000, 32'h00000000, 1'b0, 32'h0, 1'b0, 1'b0, 0);
    chk("empty done_off", done_off, 5);

    // Bit timing with alternating pattern, then three skips
    request(32'h55000000, 1'b0, 1'b0);
    run_frame("bits", 32'h55000000, 32'h55000000, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    // Handshake: second word held during frame, accepted in done cycle
    request(32'h00000031, 1'b0, 1'b0);
    run_frame("hs1", 32'h00000031, 32'h00000031, 1'b1, 32'h2A000000, 1'b0, 1'b0, 0);
    run_frame("hs2", 32'h2A000000, 32'h2A000000, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    // Reset during data bit 3 (offsets 18..21 for a slot-4 byte)
    request(32'hC3000000, 1'b0, 1'b0);
    run_frame("abort", 32'hC3000000, 32'hC3000000, 1'b0, 32'h0, 1'b0, 1'b0, 19);
    #1 rstn = 1'b0;
    #1;
    chk("arst txd", {31'h0, txd}, 32'h1);
    chk("arst busy", {31'h0, busy}, 32'h0);
    chk("arst cnt", {28'h0, cnt_o}, 32'h0);
    chk("arst ready", {31'h0, req_ready}, 32'h1);
    chk("arst all", all_o, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    request(32'h41000000, 1'b0, 1'b0);
    run_frame("post", 32'h41000000, 32'h41000000, 1'b0, 32'h0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
